// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared widths, defaults and the queue entry type for instruction fetch
package inst_fetch_queue_pkg;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] INST_NOP = '0;
  localparam int FETCH_DEPTH = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [DATA_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// inst_fetch_queue_fifo: in-order fifo of {pc, inst} entries with wrap-bit pointers
module inst_fetch_queue_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic push,
  input  logic pop,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr, rptr;
  fetch_entry_t mem [DEPTH];
  // pointer update; clear discards everything including a same-cycle push
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end
  // storage write, no reset needed since count gates visibility
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr[AW-1:0]] <= din;
  end
  assign count = wptr - rptr;
  assign head = mem[rptr[AW-1:0]];
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential instruction fetch with credit-limited queue and redirect
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic Stall,
  input  logic flush,
  input  logic [31:0] flush_pc,
  output logic imem_req,
  output logic [31:0] imem_addr,
  input  logic imem_valid,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] inst_out,
  output logic inst_en,
  output logic [31:0] inst_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);
  logic [31:0] pc, resp_pc;
  logic [CW-1:0] outstanding, discard, count, vext;
  logic keep, pop;
  fetch_entry_t head;
  assign vext = CW'(imem_valid);
  assign imem_req = !rst && !flush && (({1'b0, count} + {1'b0, outstanding}) < LIMIT);
  assign imem_addr = pc;
  assign keep = imem_valid && discard == '0 && !flush;
  assign pop = inst_en && !Stall && !flush;
  assign inst_en = count != '0;
  assign inst_out = inst_en ? head.inst : INST_NOP;
  assign inst_pc = inst_en ? head.pc : '0;
  inst_fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clear(flush),
    .push(keep),
    .pop(pop),
    .din('{pc: resp_pc, inst: imem_data}),
    .head(head),
    .count(count)
  );
  // pc, in-flight tracking and words to drop after a redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      resp_pc <= '0;
      outstanding <= '0;
      discard <= '0;
    end else if (flush) begin
      pc <= flush_pc & 32'hFFFF_FFFC;
      outstanding <= outstanding - vext;
      discard <= outstanding - vext;
    end else begin
      if (imem_req) begin
        pc <= pc + 32'd4;
        resp_pc <= pc;
      end
      outstanding <= outstanding + CW'(imem_req) - vext;
      if (imem_valid && discard != '0) discard <= discard - 1'b1;
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: queue-based reference model plus directed literal checks
module tb_inst_fetch_queue;
  localparam int D = 4;
  logic clk = 0, rst = 1, Stall = 0, flush = 0;
  logic [31:0] flush_pc = 0;
  logic imem_req, imem_valid = 0, inst_en;
  logic [31:0] imem_addr, imem_data = 0, inst_out, inst_pc;
  logic req2, valid2 = 0, en2;
  logic [31:0] addr2, data2 = 0, out2, pc2;
  int errors = 0, checks = 0;

  inst_fetch_queue #(.DEPTH(D), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .flush(flush), .flush_pc(flush_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .inst_out(inst_out), .inst_en(inst_en), .inst_pc(inst_pc));
  inst_fetch_queue #(.DEPTH(D), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .Stall(Stall), .flush(flush), .flush_pc(flush_pc),
    .imem_req(req2), .imem_addr(addr2), .imem_valid(valid2), .imem_data(data2),
    .inst_out(out2), .inst_en(en2), .inst_pc(pc2));

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a == 0 ? 32'h2001_0005 : (32'h1000_0000 ^ a);
  endfunction

  always @(posedge clk) begin
    imem_valid <= imem_req;
    imem_data <= memf(imem_addr);
    valid2 <= req2;
    data2 <= memf(addr2);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct packed { logic [31:0] addr; logic live; } fl_t;
  ent_t mq[$];
  fl_t mf[$];
  fl_t r;
  logic [31:0] mpc = 0;
  bit mvalid = 0, do_req, do_pop, have_r;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mf.delete();
      mpc = 0;
      mvalid = 1;
    end else if (mvalid) begin
      do_req = !flush && (mq.size() + mf.size() < D);
      do_pop = mq.size() != 0 && !Stall && !flush;
      have_r = 0;
      if (imem_valid && mf.size() != 0) begin
        r = mf.pop_front();
        have_r = 1;
      end
      if (flush) begin
        mq.delete();
        foreach (mf[i]) mf[i].live = 0;
        mpc = flush_pc & ~32'd3;
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (have_r && r.live) mq.push_back('{r.addr, memf(r.addr)});
        if (do_req) begin
          mf.push_back('{mpc, 1'b1});
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_req", imem_req, rst ? 0 : (!flush && (mq.size() + mf.size() < D)));
      if (imem_req) chk("model_addr", imem_addr, mpc);
      chk("model_en", inst_en, mq.size() != 0);
      chk("model_out", inst_out, mq.size() != 0 ? mq[0].inst : 32'h0);
      chk("model_pc", inst_pc, mq.size() != 0 ? mq[0].pc : 32'h0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_en;
    for (int i = 0; i < 10 && !inst_en; i++) begin
      tick();
      #1;
    end
  endtask

  initial begin
    int n;
    tick();
    tick();
    rst = 0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      #1;
      chk("stream_req", imem_req, 1);
      chk("stream_addr", imem_addr, 32'(4 * k));
      chk("wrap_addr", addr2, 32'hFFFF_FFF8 + 32'(4 * k));
      if (k >= 2) begin
        chk("stream_en", inst_en, 1);
        chk("stream_out", inst_out, memf(32'(4 * (k - 2))));
        chk("stream_pc", inst_pc, 32'(4 * (k - 2)));
        chk("wrap_pc", pc2, 32'hFFFF_FFF8 + 32'(4 * (k - 2)));
        chk("wrap_out", out2, memf(32'hFFFF_FFF8 + 32'(4 * (k - 2))));
      end else begin
        chk("early_en", inst_en, 0);
        chk("early_out", inst_out, 0);
      end
    end
    rst = 1;
    Stall = 1;
    tick();
    rst = 0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (imem_req) begin
        chk("stall_addr", imem_addr, 32'(4 * n));
        n++;
      end
      if (c >= 2) chk("stall_hold", inst_out, 32'h2001_0005);
      tick();
    end
    chk("stall_reqs", n, 4);
    Stall = 0;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("release_pc", inst_pc, 32'(4 * j));
      chk("release_out", inst_out, memf(32'(4 * j)));
      if (j == 0) chk("release_noreq", imem_req, 0);
      if (j == 1) begin
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, 32'h10);
      end
      tick();
    end
    rst = 1;
    Stall = 1;
    tick();
    rst = 0;
    tick();
    tick();
    tick();
    #1;
    chk("preflush_en", inst_en, 1);
    chk("preflush_pc", inst_pc, 0);
    flush = 1;
    flush_pc = 32'h0000_0103;
    #1;
    chk("flush_noreq", imem_req, 0);
    tick();
    flush = 0;
    Stall = 0;
    #1;
    chk("postflush_en", inst_en, 0);
    chk("postflush_req", imem_req, 1);
    chk("postflush_addr", imem_addr, 32'h100);
    wait_en();
    chk("flush_first_en", inst_en, 1);
    chk("flush_first_pc", inst_pc, 32'h100);
    chk("flush_first_out", inst_out, memf(32'h100));
    tick();
    tick();
    flush = 1;
    flush_pc = 32'h200;
    tick();
    flush_pc = 32'h302;
    tick();
    flush = 0;
    #1;
    chk("b2b_en", inst_en, 0);
    chk("b2b_addr", imem_addr, 32'h300);
    wait_en();
    chk("b2b_pc", inst_pc, 32'h300);
    Stall = 1;
    for (int i = 0; i < 8; i++) tick();
    #1;
    chk("full_en", inst_en, 1);
    chk("full_noreq", imem_req, 0);
    rst = 1;
    #1;
    chk("rst_noreq", imem_req, 0);
    tick();
    rst = 0;
    #1;
    chk("rst_en", inst_en, 0);
    chk("rst_out", inst_out, 0);
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_req", imem_req, 1);
    Stall = 0;
    for (int i = 0; i < 6; i++) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Producer side of the decode stage's instruction interface; it generates the `inst_in`/`inst_en` stream that decode consumes and honours its `Stall`.
- Holds the PC and issues sequential word fetches to instruction memory (fixed 1-cycle read latency).
- Buffers returned words in a small in-order queue and presents the head instruction with its PC.
- Supports a synchronous redirect (flush) for future branch/jump resolution.

Parameters:
- DEPTH, 4: queue entries, power of 2, minimum 2; also the credit limit on occupancy plus outstanding fetches.
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word aligned.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Stall  in  1  decode stall; head instruction is not consumed while high.
- flush  in  1  redirect request; discard all buffered and in-flight instructions.
- flush_pc  in  32  new fetch PC, valid with flush; bits [1:0] ignored (treated as 0).
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  32  byte address of the request; bits [1:0] always 0.
- imem_valid  in  1  read data valid; asserted exactly one cycle after each accepted imem_req.
- imem_data  in  `data_lentgh  returned instruction word.
- inst_out  out  `data_lentgh  head instruction, drives decode `inst_in`.
- inst_en  out  1  head valid, drives decode `inst_en`.
- inst_pc  out  32  PC of the head instruction.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=RESET_PC; queue empty; outstanding=0; discard=0.
  - Outputs: imem_req=0, inst_en=0, inst_out=`Inst_Nop (32'h0), inst_pc=0.
  - Environment requirement: imem_valid=0 in the cycle following any rst=1 cycle.
- Request issue:
  - imem_req=1 iff !rst && !flush && (count+outstanding < DEPTH).
  - imem_addr=pc.
  - On issue: pc<=pc+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0. outstanding increments.
- Response:
  - imem_valid decrements outstanding.
  - If discard>0: decrement discard and drop the word.
  - Otherwise push {imem_data, its PC} at the tail. The PC comes from a response-PC register captured at issue.
- Request and response in the same cycle: outstanding is unchanged.
- Output:
  - inst_en=(count!=0), combinational from registered state.
  - inst_out/inst_pc = head entry. When empty: inst_out=`Inst_Nop, inst_pc=0.
- Pop:
  - Occurs when inst_en && !Stall && !flush.
  - Push and pop in the same cycle: count unchanged, order preserved.
- Overflow: impossible by credit rule. Credit uses current count/outstanding, so a pop frees a slot starting the next cycle.
- Bypass: none. A word returned while the queue is empty appears on inst_out one cycle after imem_valid.
  - Fetch-to-decode latency: req at cycle N, imem_valid at N+1, inst_en at N+2.
- Flush (priority over Stall, pop, push):
  - Queue emptied; pc<=flush_pc & ~3.
  - discard<=outstanding − imem_valid (words still in flight after this edge); outstanding<=same value.
  - No request in the flush cycle. First request at flush_pc the following cycle, if credit allows.
- Back-to-back flush cycles: the last one wins; discard accumulates correctly per the rule above.
- Reset during operation: all state is cleared regardless of Stall/flush.

Decomposition:
- Additions to define.v:
  - `Inst_Nop 32'h0000_0000
  - `Fetch_Depth 4 (default for DEPTH)
  - `Reset_PC 32'h0000_0000
- Sub-module inst_fifo:
  - Synchronous FIFO of {pc, inst} entries, DEPTH entries, pointers with wrap bit.
  - Signals: push, pop, clear, count.
  - Implemented once, reusable by a future issue queue.
- Top-level logic: PC register, outstanding/discard counters, credit compare, response-PC register.

Test Plan:
- Reset release, imem returns 32'h2001_0005 for addr 0 → imem_req=1, imem_addr=0 in the first cycle after rst; inst_en=1, inst_out=32'h2001_0005, inst_pc=0 two cycles later. inst_out=0 and inst_en=0 before that.
- Streaming with Stall=0 and words A,B,C,D,E at addrs 0..16 → one request per cycle. inst_out sequence A..E with inst_pc 0,4,8,12,16 on consecutive cycles.
- Stall held 10 cycles from reset → exactly 4 requests (addrs 0,4,8,12), then imem_req=0. inst_out holds A. Release gives A,B,C,D in order and requests resume at 16.
- Flush with flush_pc=32'h0000_0103 while 1 response is in flight and 2 queued:
  - Next cycle: inst_en=0, and the in-flight word is dropped.
  - The following request has imem_addr=32'h100.
  - The first valid inst_pc is 32'h100.
- RESET_PC=32'hFFFF_FFF8 → addrs FFFF_FFF8, FFFF_FFFC, 0, 4; inst_pc matches.
- rst asserted mid-stream with queue full and Stall=1 → next cycle inst_en=0, imem_req=0, and the fetch restarts at RESET_PC after release.
